// File: rtl/decode_stage.sv
// decode_stage -- single-entry instruction decode stage with valid/ready handshake.
//
// Splits a raw instruction into register addresses, function fields, a
// sign-extended immediate and control flags, and holds the result in an
// output register. One cycle of latency, full throughput.
//
// Optional feature (macro DECODE_SCOREBOARD_EN): a load-use scoreboard of
// 2**REG_AW pending bits. It stalls intake of instructions that read a
// register still waiting for a load writeback.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o  instruction handshake, instr_i = raw instruction
//   flush_i               drop the held bundle and block intake this cycle
//   wb_valid_i, wb_rd_i   load writeback (used only with the scoreboard)
//   out_valid_o/out_ready_i decoded bundle handshake
//   op_o, rd_o, rs1_addr_o, rs2_addr_o, func_o, func_hi_o, imm_o  decode fields
//   reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o  control flags
module decode_stage #(
  parameter int ILEN   = 16,
  parameter int REG_AW = 3,
  parameter int XLEN   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ILEN-1:0]            instr_i,
  input  logic                       flush_i,
  input  logic                       wb_valid_i,
  input  logic [REG_AW-1:0]          wb_rd_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [2:0]                 op_o,
  output logic [REG_AW-1:0]          rd_o,
  output logic [REG_AW-1:0]          rs1_addr_o,
  output logic [REG_AW-1:0]          rs2_addr_o,
  output logic [REG_AW-1:0]          func_o,
  output logic [ILEN-3-3*REG_AW-1:0] func_hi_o,
  output logic [XLEN-1:0]            imm_o,
  output logic                       reg_write_o,
  output logic                       mem_read_o,
  output logic                       mem_write_o,
  output logic                       branch_o,
  output logic                       jump_o,
  output logic                       illegal_o
);

  localparam int HW = ILEN - 3 - 3*REG_AW;  // high field width
  localparam int JW = ILEN - 3 - REG_AW;    // jump immediate width

  localparam logic [2:0] OP_R = 3'b000;
  localparam logic [2:0] OP_I = 3'b001;
  localparam logic [2:0] OP_L = 3'b010;
  localparam logic [2:0] OP_S = 3'b011;
  localparam logic [2:0] OP_B = 3'b100;
  localparam logic [2:0] OP_J = 3'b101;

  typedef struct packed {
    logic              illegal;
    logic              jump;
    logic              branch;
    logic              mem_write;
    logic              mem_read;
    logic              reg_write;
    logic [XLEN-1:0]   imm;
    logic [HW-1:0]     func_hi;
    logic [REG_AW-1:0] func;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rd;
    logic [2:0]        op;
  } bundle_t;

  function automatic logic signed [XLEN-1:0] sext_h(input logic signed [HW-1:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext_j(input logic signed [JW-1:0] v);
    return XLEN'(v);
  endfunction

  logic [2:0]         f_op;
  logic [REG_AW-1:0]  f_a, f_b, f_c;
  logic signed [HW-1:0] f_h;
  logic signed [JW-1:0] f_j;

  assign f_op = instr_i[2:0];
  assign f_a  = instr_i[3 +: REG_AW];
  assign f_b  = instr_i[3+REG_AW +: REG_AW];
  assign f_c  = instr_i[3+2*REG_AW +: REG_AW];
  assign f_h  = instr_i[ILEN-1 : 3+3*REG_AW];
  assign f_j  = instr_i[ILEN-1 : 3+REG_AW];

  bundle_t bundle_d, bundle_q;
  logic    valid_q;
  logic    hazard;
  logic    fire_in, fire_out;

  // Decode: combinational from instr_i; fields not used by an opcode stay 0.
  always_comb begin
    bundle_d    = '0;
    bundle_d.op = f_op;
    case (f_op)
      OP_R: begin
        bundle_d.rd        = f_a;
        bundle_d.rs1       = f_b;
        bundle_d.rs2       = f_c;
        bundle_d.func_hi   = f_h;
        bundle_d.reg_write = 1'b1;
      end
      OP_I, OP_L: begin
        bundle_d.rd        = f_a;
        bundle_d.rs1       = f_b;
        bundle_d.func      = f_c;
        bundle_d.imm       = sext_h(f_h);
        bundle_d.reg_write = 1'b1;
        bundle_d.mem_read  = (f_op == OP_L);
      end
      OP_S, OP_B: begin
        bundle_d.rs2       = f_a;
        bundle_d.rs1       = f_b;
        bundle_d.func      = f_c;
        bundle_d.imm       = sext_h(f_h);
        bundle_d.mem_write = (f_op == OP_S);
        bundle_d.branch    = (f_op == OP_B);
      end
      OP_J: begin
        bundle_d.rd        = f_a;
        bundle_d.imm       = sext_j(f_j);
        bundle_d.reg_write = 1'b1;
        bundle_d.jump      = 1'b1;
      end
      default: bundle_d.illegal = 1'b1;
    endcase
  end

  assign in_ready_o = (!valid_q || out_ready_i) && !flush_i && !hazard;
  assign fire_in    = in_valid_i && in_ready_o;
  assign fire_out   = valid_q && out_ready_i;

`ifdef DECODE_SCOREBOARD_EN
  logic [2**REG_AW-1:0] pend_q, pend_d;
  logic                 use_rs1, use_rs2;
  logic [REG_AW-1:0]    src2;

  // R/S/B read two sources (rs2 sits in C for R, in A for S/B); I/L read one.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    src2    = f_c;
    case (f_op)
      OP_R:       begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_S, OP_B: begin use_rs1 = 1'b1; use_rs2 = 1'b1; src2 = f_a; end
      OP_I, OP_L: use_rs1 = 1'b1;
      default:    ;
    endcase
    hazard = in_valid_i && ((use_rs1 && pend_q[f_b]) || (use_rs2 && pend_q[src2]));
  end

  // Set is applied after clear so a load leaving this cycle wins over a
  // writeback to the same register. Flush leaves pending bits alone.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid_i) pend_d[wb_rd_i] = 1'b0;
    if (fire_out && bundle_q.mem_read && (bundle_q.rd != '0)) pend_d[bundle_q.rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid_i, wb_rd_i};
  assign hazard    = 1'b0;
`endif

  // Output register: flush beats both handshakes; data holds while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (flush_i) begin
      valid_q  <= 1'b0;
    end else if (fire_in) begin
      valid_q  <= 1'b1;
      bundle_q <= bundle_d;
    end else if (fire_out) begin
      valid_q  <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign op_o        = bundle_q.op;
  assign rd_o        = bundle_q.rd;
  assign rs1_addr_o  = bundle_q.rs1;
  assign rs2_addr_o  = bundle_q.rs2;
  assign func_o      = bundle_q.func;
  assign func_hi_o   = bundle_q.func_hi;
  assign imm_o       = bundle_q.imm;
  assign reg_write_o = bundle_q.reg_write;
  assign mem_read_o  = bundle_q.mem_read;
  assign mem_write_o = bundle_q.mem_write;
  assign branch_o    = bundle_q.branch;
  assign jump_o      = bundle_q.jump;
  assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] instr_i = '0;
  logic        flush_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic [2:0]  wb_rd_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [2:0]  op_o, rd_o, rs1_addr_o, rs2_addr_o, func_o;
  logic [3:0]  func_hi_o;
  logic [15:0] imm_o;
  logic        reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o;

  decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .op_o(op_o), .rd_o(rd_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .func_o(func_o),
    .func_hi_o(func_hi_o), .imm_o(imm_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
    .jump_o(jump_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_emit = 0;
  logic        last_rdy;
  logic [40:0] hold[$];    // bundle expected on the outputs (0 or 1 entries)
  bit   [7:0]  pend = '0;  // expected pending registers (scoreboard build)

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] observed();
    return {illegal_o, jump_o, branch_o, mem_write_o, mem_read_o, reg_write_o,
            imm_o, func_hi_o, func_o, rs2_addr_o, rs1_addr_o, rd_o, op_o};
  endfunction

  // Reference decode from the field rules, using plain integer arithmetic.
  function automatic logic [40:0] model(input logic [15:0] ins);
    int op = ins & 7, a = (ins >> 3) & 7, b = (ins >> 6) & 7, c = (ins >> 9) & 7;
    int h = (ins >> 12) & 15, j = (ins >> 6) & 1023;
    int hs = (h >= 8) ? h - 16 : h;
    int js = (j >= 512) ? j - 1024 : j;
    int rd = 0, rs1 = 0, rs2 = 0, fn = 0, fh = 0, imm = 0;
    bit rw = 0, mr = 0, mw = 0, br = 0, jp = 0, il = 0;
    case (op)
      0:       begin rd = a; rs1 = b; rs2 = c; fh = h; rw = 1; end
      1, 2:    begin rd = a; rs1 = b; fn = c; imm = hs; rw = 1; mr = (op == 2); end
      3, 4:    begin rs2 = a; rs1 = b; fn = c; imm = hs; mw = (op == 3); br = (op == 4); end
      5:       begin rd = a; imm = js; rw = 1; jp = 1; end
      default: il = 1;
    endcase
    return {il, jp, br, mw, mr, rw, 16'(imm), 4'(fh), 3'(fn), 3'(rs2), 3'(rs1), 3'(rd), 3'(op)};
  endfunction

  function automatic bit reads_pend(input logic [15:0] ins);
    int op = ins & 7, a = (ins >> 3) & 7, b = (ins >> 6) & 7, c = (ins >> 9) & 7;
    case (op)
      0:       return pend[b] || pend[c];
      3, 4:    return pend[b] || pend[a];
      1, 2:    return pend[b];
      default: return 0;
    endcase
  endfunction

  // One clock: drive, check against the model, advance the model, return #1 after the edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic ordy,
                      input logic fl, input logic wbv, input logic [2:0] wbr);
    logic        exp_rdy, emit;
    logic [40:0] b0;
    @(negedge clk_i);
    rst_i = 1'b0; in_valid_i = v; instr_i = ins; out_ready_i = ordy;
    flush_i = fl; wb_valid_i = wbv; wb_rd_i = wbr;
    #1;
    exp_rdy  = (hold.size() == 0 || ordy) && !fl && !(v && reads_pend(ins));
    last_rdy = in_ready_o;
    check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    check("out_valid", 64'(out_valid_o), 64'(hold.size() != 0));
    b0 = '0;
    if (hold.size() != 0) begin
      b0 = hold[0];
      check("bundle", 64'(observed()), 64'(b0));
    end
    emit = (hold.size() != 0) && ordy;
`ifdef DECODE_SCOREBOARD_EN
    if (wbv) pend[wbr] = 1'b0;
    if (emit && b0[36] && b0[5:3] != 0) pend[b0[5:3]] = 1'b1;
`endif
    if (fl) hold.delete();
    else begin
      if (emit) begin
        void'(hold.pop_front());
        n_emit++;
      end
      if (v && exp_rdy) hold.push_back(model(ins));
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic ordy);
    @(negedge clk_i);
    rst_i = 1'b1; in_valid_i = 1'($urandom); instr_i = 16'($urandom);
    out_ready_i = ordy; flush_i = 1'b0; wb_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    hold.delete();
    pend = '0;
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_outputs", 64'(observed()), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0; in_valid_i = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready_o), 64'(1));
  endtask

  logic [40:0] snap;

  initial begin
    repeat (2) @(posedge clk_i);
    do_reset(1'b0);

    // Reference R instruction
    step(1, 16'h1CC8, 1, 0, 0, 0);
    check("r_valid", 64'(out_valid_o), 64'(1));
    check("r_rd", 64'(rd_o), 64'(1));
    check("r_rs1", 64'(rs1_addr_o), 64'(3));
    check("r_rs2", 64'(rs2_addr_o), 64'(6));
    check("r_func_hi", 64'(func_hi_o), 64'(1));
    check("r_reg_write", 64'(reg_write_o), 64'(1));

    // Immediate sign extension
    step(1, 16'hF001, 1, 0, 0, 0);
    check("i_imm", 64'(imm_o), 64'(16'hFFFF));
    step(1, 16'hFFC5, 1, 0, 0, 0);
    check("j_imm", 64'(imm_o), 64'(16'hFFFF));
    check("j_jump", 64'(jump_o), 64'(1));

    // Illegal opcode
    step(1, 16'h5A57, 1, 0, 0, 0);
    check("ill_flag", 64'(illegal_o), 64'(1));
    check("ill_ctrl", 64'({reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o}), 64'(0));

    // Flush with an instruction offered
    step(1, 16'h1CC8, 0, 1, 0, 0);
    check("flush_valid", 64'(out_valid_o), 64'(0));
    step(0, 16'h0000, 1, 0, 0, 0);

    // Back-to-back stream then stall
    begin
      int e0;
      e0 = n_emit;
      for (int i = 0; i < 9; i++) step(1, 16'($urandom) & 16'hFFF8, 1, 0, 0, 0);
      check("b2b_emits", 64'(n_emit - e0), 64'(8));
      snap = observed();
      for (int i = 0; i < 3; i++) begin
        step(1, 16'($urandom) & 16'hFFF8, 0, 0, 0, 0);
        check("stall_rdy", 64'(last_rdy), 64'(0));
        check("stall_stable", 64'(observed()), 64'(snap));
      end
    end

    // Reset while a bundle is stalled
    step(1, 16'h1CC8, 0, 0, 0, 0);
    do_reset(1'b0);

`ifdef DECODE_SCOREBOARD_EN
    step(1, 16'h0012, 1, 0, 0, 0);
    step(0, 16'h0000, 1, 0, 0, 0);
    step(1, 16'h0408, 1, 0, 0, 0);
    check("sb_stall", 64'(last_rdy), 64'(0));
    step(1, 16'h0408, 1, 0, 1, 3'd2);
    check("sb_stall_wb", 64'(last_rdy), 64'(0));
    step(1, 16'h0408, 1, 0, 0, 0);
    check("sb_accept", 64'(last_rdy), 64'(1));
    step(0, 16'h0000, 1, 0, 0, 0);
    step(1, 16'h0012, 1, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 0, 0);
    do_reset(1'b1);
    step(1, 16'h0408, 1, 0, 0, 0);
    check("sb_rst_clear", 64'(last_rdy), 64'(1));
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom));
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ILEN, default 16, instruction width in bits; SHALL satisfy ILEN >= 4 + 3*REG_AW.
REQ-002 Parameter REG_AW, default 3, register address width; register file has 2**REG_AW entries.
REQ-003 Parameter XLEN, default 16, width of the sign-extended immediate output.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 in_valid_i  input  1  instruction on instr_i is valid.
REQ-007 in_ready_o  output  1  stage accepts instr_i this cycle.
REQ-008 instr_i  input  ILEN  raw instruction.
REQ-009 flush_i  input  1  discard the held output and block intake this cycle.
REQ-010 wb_valid_i  input  1  a load result is being written back this cycle.
REQ-011 wb_rd_i  input  REG_AW  destination of that writeback.
REQ-012 out_valid_o  output  1  decoded bundle is valid.
REQ-013 out_ready_i  input  1  downstream accepts the bundle.
REQ-014 op_o  output 3; rd_o, rs1_addr_o, rs2_addr_o  output REG_AW; func_o  output REG_AW; func_hi_o  output ILEN-3-3*REG_AW; imm_o  output XLEN: registered decode fields.
REQ-015 reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o  output 1 each: registered control flags.

Function
REQ-016 Field positions SHALL be: op [2:0], A=[3 +: REG_AW], B=[3+REG_AW +: REG_AW], C=[3+2*REG_AW +: REG_AW], H=[ILEN-1 : 3+3*REG_AW].
REQ-017 Opcodes: R=000, I=001, L=010, S=011, B=100, J=101; 110 and 111 SHALL set illegal_o with every other control flag 0.
REQ-018 R: rd=A, rs1=B, rs2=C, func_hi=H, imm=0; reg_write=1.
REQ-019 I/L: rd=A, rs1=B, func=C, imm=sign-extend(H) to XLEN; reg_write=1; L also mem_read=1.
REQ-020 S/B: rs2=A, rs1=B, func=C, imm=sign-extend(H); S sets mem_write=1, B sets branch=1.
REQ-021 J: rd=A, imm=sign-extend(instr_i[ILEN-1 : 3+REG_AW]); reg_write=1, jump=1.
REQ-022 Unused fields for a given opcode SHALL be driven 0.
REQ-023 Accept (fire_in) = in_valid_i & in_ready_o; emit (fire_out) = out_valid_o & out_ready_i.
REQ-024 in_ready_o = (!out_valid_o | out_ready_i) & !flush_i & !hazard, combinational.
REQ-025 On fire_in, all outputs SHALL load the decode of instr_i and out_valid_o=1 the next cycle; latency exactly 1 cycle.
REQ-026 On fire_out without fire_in, out_valid_o SHALL clear; on both, the new bundle replaces the old with no bubble (full throughput).
REQ-027 While out_valid_o & !out_ready_i, all outputs SHALL hold stable.
REQ-028 flush_i SHALL clear out_valid_o next cycle and drop any offered instruction; flush wins over fire_in and fire_out.

Reset
REQ-029 While rst_i is high at a clock edge, out_valid_o and every data/control output register SHALL become 0 and scoreboard SHALL clear.
REQ-030 Reset mid-stall or mid-transfer SHALL discard the held bundle; in_ready_o is 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro DECODE_SCOREBOARD_EN SHALL compile in a load-use scoreboard of 2**REG_AW pending bits.
REQ-032 With it: fire_out of an L op with rd!=0 SHALL set pending[rd]; wb_valid_i clears pending[wb_rd_i]; set wins on same register same cycle.
REQ-033 With it: hazard=1 when in_valid_i and instr_i reads a pending register (R,S,B read rs1 and rs2; I,L read rs1; J none); register 0 never pending.
REQ-034 With it: flush_i SHALL NOT clear pending bits.
REQ-035 Without it: hazard tied 0, no pending storage, wb_valid_i/wb_rd_i ignored.

Verification
REQ-036 Defaults, instr 0x1CC8 (R: rd=1,rs1=3,rs2=6,H=1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=3, rs2=6, func_hi=1, reg_write=1.
REQ-037 I op with H=0xF -> imm_o=0xFFFF; J op with instr[15:6]=0x3FF -> imm_o=0xFFFF, jump_o=1.
REQ-038 Back-to-back 8 instructions, out_ready held 1 -> 8 bundles on 8 consecutive cycles; then out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-039 Opcode 111 -> illegal_o=1, reg_write/mem_read/mem_write/branch/jump all 0; flush_i with in_valid=1 -> out_valid=0 next cycle, instruction dropped.
REQ-040 DECODE_SCOREBOARD_EN: load rd=2 emitted, then R reading rs2=2 -> in_ready=0 until wb_valid=1, wb_rd=2; accepted the cycle after.
REQ-041 rst_i asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all outputs 0, pending bits 0.
